regfile_writeback_arbiter: RTL and testbench

- Write-side front end of the 16x16 register file. Owns the register file's single write port (register id, data, write enable).
- Merges two result producers into that one port:
  - the single-cycle ALU, which has priority and is never stalled;
  - the memory/load path, which is buffered in a small FIFO when it loses arbitration.
- Exports a per-register pending bitmap so decode can stall reads of registers whose write has not yet reached the file.

---
 rtl/regfile_writeback_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, memory results are buffered in a squashable FIFO.
// Optional macro REGFILE_WB_ZERO_REG_EN drops every write that targets register 0.
module regfile_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [3:0]    alu_reg,
    input  logic [15:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [3:0]    mem_reg,
    input  logic [15:0]   mem_data,
    output logic [3:0]    DstReg,
    output logic [15:0]   DstData,
    output logic          WriteReg,
    output logic [15:0]   pending,
    output logic [AW:0]   fifo_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [3:0]       ent_reg_q  [DEPTH];
    logic [3:0]       ent_reg_d  [DEPTH];
    logic [15:0]      ent_data_q [DEPTH];
    logic [15:0]      ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0] ent_sq_q, ent_sq_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [3:0]       dst_reg_q, dst_reg_d;
    logic [15:0]      dst_data_q, dst_data_d;
    logic             write_reg_q, write_reg_d;

    logic alu_sel, mem_drop, fifo_empty, mem_fire, deq, bypass, enq;

    always_comb begin
        alu_sel  = alu_valid;
        mem_drop = 1'b0;
`ifdef REGFILE_WB_ZERO_REG_EN
        alu_sel  = alu_valid && (alu_reg != 4'd0);
        mem_drop = (mem_reg == 4'd0);
`endif
    end

    // Ready looks only at occupancy so it never depends on this cycle's dequeue.
    assign fifo_empty = (count_q == '0);
    assign mem_ready  = (count_q != FULL_COUNT);
    assign mem_fire   = mem_valid && mem_ready;
    assign deq        = !alu_sel && !fifo_empty;
    assign bypass     = !alu_sel && fifo_empty && mem_fire && !mem_drop;
    assign enq        = mem_fire && !mem_drop && !bypass;

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        ent_reg_d   = ent_reg_q;
        ent_data_d  = ent_data_q;
        ent_vld_d   = ent_vld_q;
        ent_sq_d    = ent_sq_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        dst_reg_d   = dst_reg_q;
        dst_data_d  = dst_data_q;
        write_reg_d = 1'b0;

        if (alu_sel) begin
            write_reg_d = 1'b1;
            dst_reg_d   = alu_reg;
            dst_data_d  = alu_data;
            // The ALU write is younger than any queued write to the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld_q[i] && (ent_reg_q[i] == alu_reg)) begin
                    ent_sq_d[i] = 1'b1;
                end
            end
        end else if (deq) begin
            write_reg_d = !ent_sq_q[rd_ptr_q];
            if (!ent_sq_q[rd_ptr_q]) begin
                dst_reg_d  = ent_reg_q[rd_ptr_q];
                dst_data_d = ent_data_q[rd_ptr_q];
            end
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + 1'b1;
        end else if (bypass) begin
            write_reg_d = 1'b1;
            dst_reg_d   = mem_reg;
            dst_data_d  = mem_data;
        end

        if (enq) begin
            ent_vld_d[wr_ptr_q]  = 1'b1;
            ent_sq_d[wr_ptr_q]   = alu_sel && (mem_reg == alu_reg);
            ent_reg_d[wr_ptr_q]  = mem_reg;
            ent_data_d[wr_ptr_q] = mem_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && !ent_sq_q[i]) begin
                pending[ent_reg_q[i]] = 1'b1;
            end
        end
        if (write_reg_q) begin
            pending[dst_reg_q] = 1'b1;
        end
`ifdef REGFILE_WB_ZERO_REG_EN
        pending[0] = 1'b0;
`endif
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld_q   <= '0;
            ent_sq_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dst_reg_q   <= '0;
            dst_data_q  <= '0;
            write_reg_q <= 1'b0;
        end else begin
            ent_vld_q   <= ent_vld_d;
            ent_sq_q    <= ent_sq_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dst_reg_q   <= dst_reg_d;
            dst_data_q  <= dst_data_d;
            write_reg_q <= write_reg_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone decide what it means.
    always_ff @(posedge clk) begin
        ent_reg_q  <= ent_reg_d;
        ent_data_q <= ent_data_d;
    end

    assign DstReg     = dst_reg_q;
    assign DstData    = dst_data_q;
    assign WriteReg   = write_reg_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed stimulus, expected writes queued, monitor compares at negedge.
module tb_regfile_writeback_arbiter;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        WriteReg;
    logic [15:0] pending;
    logic [2:0]  fifo_count;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    regfile_writeback_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .DstReg     (DstReg),
        .DstData    (DstData),
        .WriteReg   (WriteReg),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                         input logic mv, input logic [3:0] mr, input logic [15:0] md);
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] r, input logic [15:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (WriteReg === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got reg %0h data %0h expected none", DstReg, DstData);
            end else begin
                e = exp_q.pop_front();
                check("wr_reg", {28'd0, DstReg}, {28'd0, e.r});
                check("wr_data", {16'd0, DstData}, {16'd0, e.d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] t3_areg [6] = '{4'd8, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    logic [3:0] t3_mreg [6] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd7};
    logic       t3_rdy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] t3_cnt  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", {31'd0, WriteReg}, 32'd0);
        check("rst_dstreg", {28'd0, DstReg}, 32'd0);
        check("rst_dstdata", {16'd0, DstData}, 32'd0);
        check("rst_pending", {16'd0, pending}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        rst = 1'b0;
        check("rst_ready", {31'd0, mem_ready}, 32'd1);

        // Single ALU write.
        drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0);
        expect_wr(4'd3, 16'h1234);
        tick();
        check("alu_write", {31'd0, WriteReg}, 32'd1);
        check("alu_pending", {16'd0, pending}, 32'h0008);
        idle();
        tick();
        check("alu_after_write", {31'd0, WriteReg}, 32'd0);
        check("alu_after_pending", {16'd0, pending}, 32'd0);
        check("alu_hold_data", {16'd0, DstData}, 32'h1234);

        // Memory bypass with empty FIFO.
        drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF);
        check("byp_ready", {31'd0, mem_ready}, 32'd1);
        expect_wr(4'd5, 16'hBEEF);
        tick();
        check("byp_write", {31'd0, WriteReg}, 32'd1);
        check("byp_count", {29'd0, fifo_count}, 32'd0);
        check("byp_pending", {16'd0, pending}, 32'h0020);
        idle();
        tick();
        check("byp_after_write", {31'd0, WriteReg}, 32'd0);

        // ALU busy six cycles; memory fills the FIFO and then stalls.
        for (int i = 0; i < 6; i++) expect_wr(t3_areg[i], 16'hA000 + 16'(i));
        expect_wr(4'd1, 16'h1001);
        expect_wr(4'd2, 16'h2002);
        expect_wr(4'd4, 16'h4004);
        expect_wr(4'd6, 16'h6006);
        expect_wr(4'd7, 16'h7007);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, t3_areg[i], 16'hA000 + 16'(i), 1'b1, t3_mreg[i], 16'(t3_mreg[i]) * 16'h1001);
            check("full_ready", {31'd0, mem_ready}, {31'd0, t3_rdy[i]});
            tick();
            check("full_count", {29'd0, fifo_count}, {29'd0, t3_cnt[i]});
            if (i == 3) check("full_pending", {16'd0, pending}, 32'h1056);
        end
        drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7007);
        check("drain_ready_full", {31'd0, mem_ready}, 32'd0);
        tick();
        check("drain_count0", {29'd0, fifo_count}, 32'd3);
        check("drain_ready_free", {31'd0, mem_ready}, 32'd1);
        tick();
        check("drain_count1", {29'd0, fifo_count}, 32'd3);
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drain_write", {31'd0, WriteReg}, 32'd1);
            check("drain_count", {29'd0, fifo_count}, 32'(2 - k));
        end
        tick();
        check("drain_done_write", {31'd0, WriteReg}, 32'd0);
        check("drain_done_pending", {16'd0, pending}, 32'd0);

        // Queued write to reg 9 squashed by a younger ALU write.
        drive(1'b1, 4'd3, 16'h3333, 1'b1, 4'd9, 16'h0AAA);
        expect_wr(4'd3, 16'h3333);
        expect_wr(4'd9, 16'h0BBB);
        tick();
        check("sq_pending_q", {16'd0, pending}, 32'h0208);
        drive(1'b1, 4'd9, 16'h0BBB, 1'b0, 4'd0, 16'd0);
        tick();
        check("sq_count", {29'd0, fifo_count}, 32'd1);
        check("sq_pending_out", {16'd0, pending}, 32'h0200);
        idle();
        tick();
        check("sq_slot_write", {31'd0, WriteReg}, 32'd0);
        check("sq_slot_count", {29'd0, fifo_count}, 32'd0);
        check("sq_slot_pending", {16'd0, pending}, 32'd0);

        // Same-cycle enqueue to the ALU's register is enqueued squashed.
        drive(1'b1, 4'd5, 16'h5555, 1'b1, 4'd5, 16'h5AAA);
        expect_wr(4'd5, 16'h5555);
        tick();
        check("sq_same_count", {29'd0, fifo_count}, 32'd1);
        check("sq_same_pending", {16'd0, pending}, 32'h0020);
        idle();
        tick();
        check("sq_same_slot", {31'd0, WriteReg}, 32'd0);
        check("sq_same_empty", {29'd0, fifo_count}, 32'd0);

        // Reset with three queued entries discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, t3_areg[i], 16'hC000 + 16'(i), 1'b1, t3_mreg[i], 16'(t3_mreg[i]) * 16'h1001);
            expect_wr(t3_areg[i], 16'hC000 + 16'(i));
            tick();
        end
        check("rst3_count", {29'd0, fifo_count}, 32'd3);
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        check("rst3_count_clr", {29'd0, fifo_count}, 32'd0);
        check("rst3_write", {31'd0, WriteReg}, 32'd0);
        check("rst3_pending", {16'd0, pending}, 32'd0);
        check("rst3_ready", {31'd0, mem_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst3_no_write", {31'd0, WriteReg}, 32'd0);
        end

        // Register 0 is an ordinary register in the default build.
        drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
        expect_wr(4'd0, 16'hFFFF);
        tick();
        check("zero_write", {31'd0, WriteReg}, 32'd1);
        check("zero_pending", {16'd0, pending}, 32'h0001);
        idle();
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
